// File: rtl/s_axi4l_reg_arbiter.sv
// Round-robin scheduler that serializes AXI4-Lite read and write requesters
// onto a single-port register bank with a one-cycle registered read.
module s_axi4l_reg_arbiter #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 4,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                      i_axi_clock,
  input  logic                      i_axi_aresetn,
  input  logic                      i_rd_req,
  input  logic [AXI_ADDR_WIDTH-1:0] i_rd_addr,
  output logic [AXI_DATA_WIDTH-1:0] o_rd_data,
  output logic                      o_rd_done,
  input  logic                      i_wr_req,
  input  logic [AXI_ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [AXI_DATA_WIDTH-1:0] i_wr_data,
  input  logic [AXI_STRB_WIDTH-1:0] i_wr_strb,
  output logic                      o_wr_done,
  output logic [AXI_ADDR_WIDTH-1:0] o_reg_addr,
  output logic                      o_reg_ren,
  output logic                      o_reg_wen,
  output logic [AXI_DATA_WIDTH-1:0] o_reg_wdata,
  output logic [AXI_STRB_WIDTH-1:0] o_reg_wstrb,
  input  logic [AXI_DATA_WIDTH-1:0] i_reg_rdata,
  output logic                      o_busy
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    RD_RESP,
    WR_ISSUE,
    WR_RESP
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic                      prio_wr;
  logic                      grant_rd;
  logic                      grant_wr;
  logic [AXI_ADDR_WIDTH-1:0] lat_addr;
  logic [AXI_DATA_WIDTH-1:0] lat_wdata;
  logic [AXI_STRB_WIDTH-1:0] lat_wstrb;

  // Requests only matter in IDLE; prio_wr breaks ties when both sides ask.
  always_comb begin
    state_next = state;
    grant_rd   = 1'b0;
    grant_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (i_rd_req && (!i_wr_req || !prio_wr)) begin
          grant_rd   = 1'b1;
          state_next = RD_ISSUE;
        end else if (i_wr_req) begin
          grant_wr   = 1'b1;
          state_next = WR_ISSUE;
        end
      end
      RD_ISSUE:   state_next = RD_CAPTURE;
      RD_CAPTURE: state_next = RD_RESP;
      RD_RESP:    state_next = IDLE;
      WR_ISSUE:   state_next = WR_RESP;
      WR_RESP:    state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_axi_clock or negedge i_axi_aresetn) begin
    if (!i_axi_aresetn) begin
      state     <= IDLE;
      prio_wr   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
      o_rd_data <= '0;
    end else begin
      state <= state_next;
      if (grant_rd) begin
        prio_wr  <= 1'b1;
        lat_addr <= i_rd_addr;
      end
      if (grant_wr) begin
        prio_wr   <= 1'b0;
        lat_addr  <= i_wr_addr;
        lat_wdata <= i_wr_data;
        lat_wstrb <= i_wr_strb;
      end
      // The bank's registered read data is valid exactly in RD_CAPTURE.
      if (state == RD_CAPTURE) begin
        o_rd_data <= i_reg_rdata;
      end
    end
  end

  assign o_reg_ren   = (state == RD_ISSUE);
  assign o_reg_wen   = (state == WR_ISSUE);
  assign o_reg_addr  = (o_reg_ren || o_reg_wen) ? lat_addr : '0;
  assign o_reg_wdata = o_reg_wen ? lat_wdata : '0;
  assign o_reg_wstrb = o_reg_wen ? lat_wstrb : '0;
  assign o_rd_done   = (state == RD_RESP);
  assign o_wr_done   = (state == WR_RESP);
  assign o_busy      = (state != IDLE);

endmodule

// File: tb/tb_s_axi4l_reg_arbiter.sv
// Scoreboard bench: a transaction-level arbitration model queues expected bank
// accesses and completions; a negedge monitor pops and compares them.
module tb_s_axi4l_reg_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int SW = 4;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_done;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [SW-1:0] wr_strb = '0;
  logic          wr_done;
  logic [AW-1:0] reg_addr;
  logic          reg_ren;
  logic          reg_wen;
  logic [DW-1:0] reg_wdata;
  logic [SW-1:0] reg_wstrb;
  logic [DW-1:0] reg_rdata = '0;
  logic          busy;

  logic          bank_load = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic [DW-1:0] bank_mem [16];
  logic [DW-1:0] ref_mem [16];

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    int            cyc;
  } exp_t;

  exp_t          iss_q[$];
  exp_t          rdd_q[$];
  exp_t          wrd_q[$];
  exp_t          mon_e;
  exp_t          mod_e;
  bit            grant_log[$];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            model_cnt = 0;
  bit            model_prio_wr = 1'b0;
  bit            take_wr;
  logic [DW-1:0] exp_rd_data = '0;
  logic [DW-1:0] pend_rd_data = '0;
  int            pend_rd_cyc = -1;
  int            rd_grant_cyc = -1;
  int            wr_grant_cyc = -1;
  int            log_base;

  always #5 clock = ~clock;

  s_axi4l_reg_arbiter #(
    .AXI_DATA_WIDTH(DW),
    .AXI_ADDR_WIDTH(AW),
    .AXI_STRB_WIDTH(SW)
  ) dut (
    .i_axi_clock  (clock),
    .i_axi_aresetn(rst_n),
    .i_rd_req     (rd_req),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_rd_done    (rd_done),
    .i_wr_req     (wr_req),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_wr_strb    (wr_strb),
    .o_wr_done    (wr_done),
    .o_reg_addr   (reg_addr),
    .o_reg_ren    (reg_ren),
    .o_reg_wen    (reg_wen),
    .o_reg_wdata  (reg_wdata),
    .o_reg_wstrb  (reg_wstrb),
    .i_reg_rdata  (reg_rdata),
    .o_busy       (busy)
  );

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural register bank: byte-strobed writes, one-cycle registered read.
  always @(posedge clock) begin
    if (bank_load) begin
      bank_mem[load_addr] <= load_data;
    end else if (reg_wen) begin
      for (int b = 0; b < SW; b++) begin
        if (reg_wstrb[b]) bank_mem[reg_addr][8*b +: 8] <= reg_wdata[8*b +: 8];
      end
    end
    if (reg_ren) reg_rdata <= bank_mem[reg_addr];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (!rst_n) begin
      checkOutput("reset_outputs", {busy, rd_done, wr_done, reg_ren, reg_wen, reg_addr, reg_wstrb}, '0);
      checkOutput("reset_rd_data", rd_data, '0);
      checkOutput("reset_wdata", reg_wdata, '0);
      if (bank_load) ref_mem[load_addr] = load_data;
      iss_q.delete();
      rdd_q.delete();
      wrd_q.delete();
      model_cnt     = 0;
      model_prio_wr = 1'b0;
      exp_rd_data   = '0;
      pend_rd_cyc   = -1;
    end else begin
      // Monitor: bank strobes.
      checkOutput("ren_wen_exclusive", reg_ren & reg_wen, 0);
      if (reg_ren || reg_wen) begin
        grant_log.push_back(reg_wen);
        if (iss_q.size() == 0) begin
          checkOutput("unexpected_strobe", {reg_ren, reg_wen}, 0);
        end else begin
          mon_e = iss_q.pop_front();
          checkOutput("issue_cycle", cyc, mon_e.cyc);
          checkOutput("issue_kind_wen", reg_wen, mon_e.is_wr);
          checkOutput("issue_kind_ren", reg_ren, !mon_e.is_wr);
          checkOutput("issue_addr", reg_addr, mon_e.addr);
          if (mon_e.is_wr) begin
            checkOutput("issue_wdata", reg_wdata, mon_e.data);
            checkOutput("issue_wstrb", reg_wstrb, mon_e.strb);
          end
        end
      end else begin
        checkOutput("idle_bank_bus", {reg_addr, reg_wdata, reg_wstrb}, '0);
        if (iss_q.size() > 0 && iss_q[0].cyc < cyc) begin
          checkOutput("missing_strobe", cyc, iss_q[0].cyc);
          void'(iss_q.pop_front());
        end
      end
      // Monitor: read completion.
      if (rd_done) begin
        if (rdd_q.size() == 0) begin
          checkOutput("unexpected_rd_done", rd_done, 0);
        end else begin
          mon_e = rdd_q.pop_front();
          checkOutput("rd_done_cycle", cyc, mon_e.cyc);
          checkOutput("rd_done_data", rd_data, mon_e.data);
        end
      end else if (rdd_q.size() > 0 && rdd_q[0].cyc < cyc) begin
        checkOutput("missing_rd_done", cyc, rdd_q[0].cyc);
        void'(rdd_q.pop_front());
      end
      // Monitor: write completion.
      if (wr_done) begin
        if (wrd_q.size() == 0) begin
          checkOutput("unexpected_wr_done", wr_done, 0);
        end else begin
          mon_e = wrd_q.pop_front();
          checkOutput("wr_done_cycle", cyc, mon_e.cyc);
        end
      end else if (wrd_q.size() > 0 && wrd_q[0].cyc < cyc) begin
        checkOutput("missing_wr_done", cyc, wrd_q[0].cyc);
        void'(wrd_q.pop_front());
      end
      // Reference model: one access at a time, reads 3 cycles, writes 2.
      if (pend_rd_cyc == cyc) exp_rd_data = pend_rd_data;
      checkOutput("rd_data_hold", rd_data, exp_rd_data);
      checkOutput("busy", busy, model_cnt != 0);
      if (model_cnt != 0) begin
        model_cnt--;
      end else if (rd_req || wr_req) begin
        if (rd_req && wr_req) take_wr = model_prio_wr;
        else                  take_wr = wr_req;
        model_prio_wr = !take_wr;
        mod_e.is_wr = take_wr;
        mod_e.cyc   = cyc + 1;
        if (take_wr) begin
          mod_e.addr = wr_addr;
          mod_e.data = wr_data;
          mod_e.strb = wr_strb;
          iss_q.push_back(mod_e);
          mod_e.cyc = cyc + 2;
          wrd_q.push_back(mod_e);
          for (int b = 0; b < SW; b++) begin
            if (wr_strb[b]) ref_mem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
          end
          model_cnt    = 2;
          wr_grant_cyc = cyc;
        end else begin
          mod_e.addr = rd_addr;
          mod_e.data = ref_mem[rd_addr];
          mod_e.strb = '0;
          iss_q.push_back(mod_e);
          mod_e.cyc = cyc + 3;
          rdd_q.push_back(mod_e);
          pend_rd_data = mod_e.data;
          pend_rd_cyc  = cyc + 3;
          model_cnt    = 3;
          rd_grant_cyc = cyc;
        end
      end
    end
  end

  // Raise one request, optionally disturb its inputs after the grant, wait for done.
  task automatic applyStimulus(input bit is_wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [SW-1:0] strb, input int gap, input bit scramble);
    bit seen;
    bit moved;
    int start;
    repeat (gap) @(posedge clock);
    #1;
    start = cyc;
    if (is_wr) begin
      wr_addr = addr;
      wr_data = data;
      wr_strb = strb;
      wr_req  = 1'b1;
    end else begin
      rd_addr = addr;
      rd_req  = 1'b1;
    end
    seen  = 1'b0;
    moved = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clock);
      #1;
      if (is_wr ? wr_done : rd_done) begin
        seen = 1'b1;
      end else if (scramble && !moved && ((is_wr ? wr_grant_cyc : rd_grant_cyc) >= start)) begin
        @(posedge clock);
        #1;
        moved = 1'b1;
        if (is_wr) begin
          wr_addr = addr ^ 4'h4;
          wr_data = ~data;
          wr_strb = ~strb;
        end else begin
          rd_addr = addr ^ 4'h4;
        end
      end
    end
    checkOutput(is_wr ? "wr_request_completed" : "rd_request_completed", seen, 1);
    @(posedge clock);
    #1;
    if (is_wr) wr_req = 1'b0;
    else       rd_req = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic pulseReset();
    @(posedge clock);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clock);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;

    // Reset with random requester activity: everything must read zero.
    rst_n   = 1'b0;
    rd_req  = 1'($urandom);
    wr_req  = 1'($urandom);
    rd_addr = AW'($urandom);
    wr_addr = AW'($urandom);
    wr_data = $urandom;
    wr_strb = SW'($urandom);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_strobes", {reg_ren, reg_wen, rd_done, wr_done}, 0);
    checkOutput("reset_rd_data_init", rd_data, 0);
    for (int i = 0; i < 16; i++) begin
      @(posedge clock);
      #1;
      bank_load = 1'b1;
      load_addr = AW'(i);
      load_data = (i == 4) ? 32'hDEADBEEF : $urandom;
    end
    @(posedge clock);
    #1;
    bank_load = 1'b0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    rst_n     = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    checkOutput("idle_after_reset_busy", busy, 0);

    $display("[TB] single read and write");
    applyStimulus(1'b0, 4'h4, '0, '0, 0, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    checkOutput("rd_data_after_5", rd_data, 32'hDEADBEEF);
    applyStimulus(1'b1, 4'h8, 32'h12345678, 4'h3, 0, 1'b0);
    checkOutput("rd_data_after_write", rd_data, 32'hDEADBEEF);

    $display("[TB] contention");
    pulseReset();
    log_base = grant_log.size();
    fork
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, AW'(i), '0, '0, 0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, AW'(i + 8), 32'hA5A50000 + i, 4'hF, 0, 1'b0);
    join
    checkOutput("contention_count", grant_log.size() - log_base, 6);
    for (int i = 0; i < 6; i++) begin
      checkOutput("contention_order", grant_log[log_base + i], (i % 2) == 1);
    end

    $display("[TB] address stability");
    applyStimulus(1'b1, 4'h8, 32'hCAFE0001, 4'hF, 0, 1'b1);
    applyStimulus(1'b0, 4'h8, '0, '0, 0, 1'b0);
    applyStimulus(1'b0, 4'hC, '0, '0, 0, 1'b1);

    $display("[TB] reset during read capture");
    @(posedge clock);
    #1;
    rd_addr = 4'h0;
    rd_req  = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    rst_n  = 1'b0;
    rd_req = 1'b0;
    #1;
    checkOutput("midread_busy", busy, 0);
    checkOutput("midread_rd_data", rd_data, 0);
    checkOutput("midread_ren", reg_ren, 0);
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    checkOutput("midread_no_done", rd_data, 0);
    applyStimulus(1'b0, 4'h0, '0, '0, 0, 1'b0);

    $display("[TB] randomized traffic");
    fork
      for (int i = 0; i < 50; i++) begin
        a = AW'($urandom);
        applyStimulus(1'b0, a, '0, '0, int'($urandom_range(0, 3)), 1'($urandom));
      end
      for (int i = 0; i < 50; i++) begin
        a = AW'($urandom);
        d = $urandom;
        s = SW'($urandom);
        applyStimulus(1'b1, a, d, s, int'($urandom_range(0, 3)), 1'($urandom));
      end
    join
    repeat (6) @(posedge clock);
    #1;
    checkOutput("queues_drained", iss_q.size() + rdd_q.size() + wrd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/s_axi4l_reg_arbiter.md
# s_axi4l_reg_arbiter

Single-port register-bank access scheduler for the AXI4-Lite slave. It sits between the slave's read-side and write-side request logic and one register bank that has a single address port and a one-cycle registered read. It serializes the two requesters with alternating (round-robin) priority, drives the bank strobes for exactly one cycle per access, and returns completion pulses and read data to the requesters.

## Interface
Parameters:
- AXI_DATA_WIDTH, default 32: register and data width.
- AXI_ADDR_WIDTH, default 4: register address width.
- AXI_STRB_WIDTH, default AXI_DATA_WIDTH/8: write strobe width.

Ports:
- i_axi_clock, in, 1: the single clock; everything is on its rising edge.
- i_axi_aresetn, in, 1: reset, asynchronous, active-low.
- i_rd_req, in, 1: read request; held high until o_rd_done, dropped the cycle after.
- i_rd_addr, in, AXI_ADDR_WIDTH: read address; stable while i_rd_req is high.
- o_rd_data, out, AXI_DATA_WIDTH: captured read data.
- o_rd_done, out, 1: one-cycle read completion pulse.
- i_wr_req, in, 1: write request; same holding rule as i_rd_req.
- i_wr_addr, in, AXI_ADDR_WIDTH: write address.
- i_wr_data, in, AXI_DATA_WIDTH: write data.
- i_wr_strb, in, AXI_STRB_WIDTH: write byte strobes.
- o_wr_done, out, 1: one-cycle write completion pulse.
- o_reg_addr, out, AXI_ADDR_WIDTH: bank address.
- o_reg_ren, out, 1: bank read strobe.
- o_reg_wen, out, 1: bank write strobe.
- o_reg_wdata, out, AXI_DATA_WIDTH: bank write data.
- o_reg_wstrb, out, AXI_STRB_WIDTH: bank write strobes.
- i_reg_rdata, in, AXI_DATA_WIDTH: bank read data; valid the cycle after o_reg_ren.
- o_busy, out, 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, RD_ISSUE, RD_CAPTURE, RD_RESP, WR_ISSUE, WR_RESP.
- IDLE transitions:
  - Only i_rd_req high -> RD_ISSUE.
  - Only i_wr_req high -> WR_ISSUE.
  - Both high -> the side indicated by the priority bit.
  - Neither -> stay in IDLE.
- Requests are sampled only in IDLE. In all other states they are ignored.
- Grant latching: on the IDLE exit edge, latch the granted side's address, plus data and strobes for a write. Requester inputs are don't-care after that edge.
- Priority bit:
  - Reset value selects read.
  - A read grant sets priority to write.
  - A write grant sets priority to read.
  - The bit updates on every grant, contended or not.
- Read path:
  - RD_ISSUE: o_reg_ren=1, o_reg_addr=latched address. Next state RD_CAPTURE.
  - RD_CAPTURE: register i_reg_rdata into o_rd_data. Next state RD_RESP.
  - RD_RESP: o_rd_done=1. Next state IDLE.
- Write path:
  - WR_ISSUE: o_reg_wen=1; o_reg_addr, o_reg_wdata and o_reg_wstrb driven from the latched values. Next state WR_RESP.
  - WR_RESP: o_wr_done=1. Next state IDLE.
- Outside its ISSUE state:
  - o_reg_addr, o_reg_wdata and o_reg_wstrb are 0.
  - o_reg_ren and o_reg_wen are never high together.
- o_rd_data holds its value until the next RD_CAPTURE. Writes never change it.
- Requester side: the requester must drop its request on the edge where it sees done. IDLE therefore never re-grants a completed request.
- No address decode or error reporting. The bank owns out-of-range behaviour.

## Timing
- Reset values (asynchronous, immediate on assertion):
  - State IDLE, priority=read.
  - o_rd_data=0 and all latched fields 0.
  - All outputs 0, including o_busy.
- Reset mid-operation:
  - Any in-flight access is abandoned. No done pulse is produced.
  - o_reg_ren and o_reg_wen drop in the same cycle reset asserts.
  - The first edge after deassertion evaluates IDLE normally.
- Read latency, with the request high in IDLE cycle T:
  - o_reg_ren at T+1.
  - Capture at T+2.
  - o_rd_done at T+3.
- Write latency, with the request high in IDLE at T:
  - o_reg_wen at T+1.
  - o_wr_done at T+2.
- Throughput: the next grant is possible in the IDLE cycle after a RESP state. Minimum spacing is 4 cycles per read and 3 per write.
- Done pulses, bank strobes and o_busy are decoded from state. All stored values are flops; there is no combinational path from requester inputs to outputs.

## Test plan
- Reset and idle: assert i_axi_aresetn=0 with random inputs -> all outputs 0. After release with no requests, o_busy stays 0 for 10 cycles.
- Single read: addr 0x4, bank returns 0xDEADBEEF the cycle after ren.
  - o_reg_ren=1 with o_reg_addr=0x4 at T+1.
  - o_rd_done is a single pulse at T+3 with o_rd_data=0xDEADBEEF.
  - o_rd_data still reads 0xDEADBEEF 5 cycles later.
- Single write: addr 0x8, data 0x12345678, strb 0x3.
  - o_reg_wen is high for exactly one cycle at T+1 with those values.
  - o_wr_done at T+2.
  - o_rd_data is unchanged.
- Contention: after reset, i_rd_req and i_wr_req rise together for three rounds (requesters re-request immediately after done).
  - Grant order is R, W, R, W, R, W.
  - ren and wen are never high in the same cycle.
- Address stability: change i_wr_addr from 0x8 to 0xC one cycle after grant -> the bank still sees 0x8 on o_reg_addr.
- Reset mid-read: assert reset during RD_CAPTURE.
  - No o_rd_done pulse; o_rd_data=0.
  - A read of 0x0 issued after release completes with normal T+3 latency.
